alu40: RTL and testbench



---
 rtl/alu40_pkg.sv | 47 ++++
 rtl/alu40_shift.sv | 41 ++++
 rtl/alu40.sv | 79 +++++++
 tb/tb_alu40.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu40_pkg.sv
// alu40 shared definitions: width, opcode encoding and shifter modes.
// Imported by the ALU top and its barrel shifter.
package alu40_pkg;

    localparam int W = 40;
    localparam int AMTW = 6;

    typedef enum logic [4:0] {
        OP_PASSA = 5'h00,
        OP_PASSB = 5'h01,
        OP_NOTA  = 5'h02,
        OP_NEG   = 5'h03,
        OP_INC   = 5'h04,
        OP_ADD   = 5'h05,
        OP_SUB   = 5'h06,
        OP_RSUB  = 5'h07,
        OP_AND   = 5'h08,
        OP_OR    = 5'h09,
        OP_XOR   = 5'h0A,
        OP_MUL   = 5'h0B,
        OP_SHL   = 5'h0C,
        OP_SHR   = 5'h0D,
        OP_SAR   = 5'h0E,
        OP_ROL   = 5'h0F,
        OP_SLT   = 5'h10,
        OP_SLTU  = 5'h11,
        OP_ABS   = 5'h12,
        OP_MAX   = 5'h13,
        OP_MIN   = 5'h14,
        OP_DEC   = 5'h15,
        OP_XNOR  = 5'h16,
        OP_NOR   = 5'h17
    } op_e;

    // Encoded to match the low two opcode bits of OP_SHL..OP_ROL.
    typedef enum logic [1:0] {
        SH_SHL = 2'b00,
        SH_SHR = 2'b01,
        SH_SAR = 2'b10,
        SH_ROL = 2'b11
    } shmode_e;

    function automatic logic [W-1:0] flag(input logic f);
        return {{(W-1){1'b0}}, f};
    endfunction

endpackage

// File: rtl/alu40_shift.sv
// alu40 barrel shifter/rotator: left/right logical, arithmetic right
// and rotate-left of a 40-bit operand by a 6-bit amount.
module alu40_shift
    import alu40_pkg::*;
(
    input  logic [W-1:0]    a,
    input  logic [AMTW-1:0] amt,
    input  shmode_e         mode,
    output logic [W-1:0]    y
);

    logic            ovr;
    logic [AMTW-1:0] rot;
    logic [2*W-1:0]  dbl;
    logic [W-1:0]    shl;
    logic [W-1:0]    shr;
    logic [W-1:0]    sar;
    logic [W-1:0]    sfill;

    // Amounts 40..63 only need one subtraction to reduce mod 40.
    assign ovr   = amt >= AMTW'(W);
    assign rot   = ovr ? amt - AMTW'(W) : amt;
    assign dbl   = {a, a} << rot;
    assign sfill = {W{a[W-1]}};

    assign shl = ovr ? '0 : a << amt;
    assign shr = ovr ? '0 : a >> amt;
    assign sar = ovr ? sfill : $unsigned($signed(a) >>> amt);

    always_comb begin
        y = '0;
        unique case (mode)
            SH_SHL:  y = shl;
            SH_SHR:  y = shr;
            SH_SAR:  y = sar;
            SH_ROL:  y = dbl[2*W-1:W];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu40.sv
// alu40: registered 40-bit integer ALU, 24 opcodes, one-cycle latency.
// Result register clears asynchronously on rst_n low.
module alu40
    import alu40_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [4:0]   s,
    input  logic         clk,
    output logic [W-1:0] out,
    input  logic         rst_n
);

    logic [W-1:0] f;
    logic [W-1:0] sum;
    logic [W-1:0] dif;
    logic [W-1:0] rdif;
    logic [W-1:0] neg;
    logic [W-1:0] prod;
    logic [W-1:0] shy;
    logic         slt;
    logic         ult;
    shmode_e      shmode;

    assign sum  = a + b;
    assign dif  = a - b;
    assign rdif = b - a;
    assign neg  = '0 - a;
    assign prod = a * b;
    assign slt  = $signed(a) < $signed(b);
    assign ult  = a < b;

    assign shmode = shmode_e'(s[1:0]);

    alu40_shift u_shift (
        .a    (a),
        .amt  (b[AMTW-1:0]),
        .mode (shmode),
        .y    (shy)
    );

    // Reserved opcodes 18..1F fall through to zero.
    always_comb begin
        f = '0;
        case (s)
            OP_PASSA: f = a;
            OP_PASSB: f = b;
            OP_NOTA:  f = ~a;
            OP_NEG:   f = neg;
            OP_INC:   f = a + W'(1);
            OP_ADD:   f = sum;
            OP_SUB:   f = dif;
            OP_RSUB:  f = rdif;
            OP_AND:   f = a & b;
            OP_OR:    f = a | b;
            OP_XOR:   f = a ^ b;
            OP_MUL:   f = prod;
            OP_SHL,
            OP_SHR,
            OP_SAR,
            OP_ROL:   f = shy;
            OP_SLT:   f = flag(slt);
            OP_SLTU:  f = flag(ult);
            OP_ABS:   f = a[W-1] ? neg : a;
            OP_MAX:   f = slt ? b : a;
            OP_MIN:   f = slt ? a : b;
            OP_DEC:   f = a - W'(1);
            OP_XNOR:  f = ~(a ^ b);
            OP_NOR:   f = ~(a | b);
            default:  f = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= '0;
        else        out <= f;
    end

endmodule

// File: tb/tb_alu40.sv
// tb_alu40: directed vectors; expected results queued by the driver
// and checked by an independent monitor one edge later.
module tb_alu40;

    logic [39:0] a;
    logic [39:0] b;
    logic [4:0]  s;
    logic        clk;
    logic        rst_n;
    logic [39:0] out;

    typedef struct {
        string       name;
        logic [39:0] exp;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;

    alu40 dut (
        .a     (a),
        .b     (b),
        .s     (s),
        .clk   (clk),
        .out   (out),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [39:0] act,
                       input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [39:0] ta,
                         input logic [39:0] tb, input logic [4:0] ts,
                         input logic [39:0] e);
        exp_t item;
        @(negedge clk);
        a = ta;
        b = tb;
        s = ts;
        item.name = nm;
        item.exp  = e;
        q.push_back(item);
    endtask

    task automatic hold(input string nm, input logic [39:0] ta,
                        input logic [39:0] tb, input logic [4:0] ts,
                        input logic [39:0] e, input int n);
        for (int i = 0; i < n; i++) issue(nm, ta, tb, ts, e);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst", out, 40'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold", out, 40'h0);
        rst_n = 1'b1;
    endtask

    // Monitor: the DUT presents a fresh result after every edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && q.size() > 0) begin
            cur = q.pop_front();
            chk(cur.name, out, cur.exp);
        end
    end

    initial begin
        exp_t item;
        rst_n = 1'b0;
        a = 40'h0B;
        b = 40'h03;
        s = 5'h05;
        repeat (2) @(negedge clk);
        chk("rst_init", out, 40'h0);

        @(negedge clk);
        rst_n = 1'b1;
        item.name = "rel_add";
        item.exp  = 40'h0E;
        q.push_back(item);

        hold("sw_add", 40'h0B, 40'h03, 5'h05, 40'h0E, 2);
        hold("sw_sub", 40'h0B, 40'h03, 5'h06, 40'h08, 3);
        hold("sw_and", 40'h0B, 40'h03, 5'h08, 40'h03, 3);
        hold("sw_mul", 40'h0B, 40'h03, 5'h0B, 40'h21, 3);
        hold("sw_add2", 40'h0B, 40'h03, 5'h05, 40'h0E, 2);

        issue("passa", 40'h0B, 40'h03, 5'h00, 40'h0B);
        issue("passb", 40'h0B, 40'h03, 5'h01, 40'h03);
        issue("nota", 40'h0B, 40'h03, 5'h02, 40'hFF_FFFF_FFF4);
        issue("neg", 40'h0B, 40'h03, 5'h03, 40'hFF_FFFF_FFF5);
        issue("inc", 40'h0B, 40'h03, 5'h04, 40'h0C);
        issue("rsub", 40'h0B, 40'h03, 5'h07, 40'hFF_FFFF_FFF8);
        issue("or", 40'h0B, 40'h03, 5'h09, 40'h0B);
        issue("xor", 40'h0B, 40'h03, 5'h0A, 40'h08);
        issue("xnor", 40'h0B, 40'h03, 5'h16, 40'hFF_FFFF_FFF7);
        issue("nor", 40'h0B, 40'h03, 5'h17, 40'hFF_FFFF_FFF4);

        issue("add_wrap", 40'hFF_FFFF_FFFF, 40'h1, 5'h05, 40'h0);
        issue("slt", 40'hFF_FFFF_FFFF, 40'h0, 5'h10, 40'h1);
        issue("sltu", 40'hFF_FFFF_FFFF, 40'h0, 5'h11, 40'h0);
        issue("abs_min", 40'h80_0000_0000, 40'h0, 5'h12,
              40'h80_0000_0000);
        issue("abs_neg", 40'hFF_FFFF_FFFD, 40'h0, 5'h12, 40'h3);
        issue("max", 40'hFF_FFFF_FFFF, 40'h3, 5'h13, 40'h3);
        issue("min", 40'hFF_FFFF_FFFF, 40'h3, 5'h14, 40'hFF_FFFF_FFFF);
        issue("dec0", 40'h0, 40'h0, 5'h15, 40'hFF_FFFF_FFFF);

        issue("shl1", 40'h80_0000_0001, 40'd1, 5'h0C, 40'h2);
        issue("sar4", 40'h80_0000_0001, 40'd4, 5'h0E, 40'hF8_0000_0000);
        issue("rol1", 40'h80_0000_0001, 40'd1, 5'h0F, 40'h3);
        issue("shr40", 40'h80_0000_0001, 40'd40, 5'h0D, 40'h0);
        issue("sar40", 40'h80_0000_0001, 40'd40, 5'h0E, 40'hFF_FFFF_FFFF);
        issue("shl39", 40'h1, 40'd39, 5'h0C, 40'h80_0000_0000);
        issue("shl63", 40'h1, 40'd63, 5'h0C, 40'h0);
        issue("rol41", 40'h80_0000_0001, 40'd41, 5'h0F, 40'h3);
        issue("rol0", 40'h80_0000_0001, 40'd0, 5'h0F, 40'h80_0000_0001);
        issue("shr4", 40'h80_0000_0001, 40'd4, 5'h0D, 40'h08_0000_0000);

        issue("rsvd1a", 40'h12_3456_789A, 40'h55, 5'h1A, 40'h0);
        issue("rsvd1f", 40'hFF_FFFF_FFFF, 40'hFF, 5'h1F, 40'h0);
        issue("mul_trunc", 40'h10_0000_0000, 40'h100, 5'h0B, 40'h0);
        issue("mul_neg", 40'hFF_FFFF_FFFF, 40'h5, 5'h0B, 40'hFF_FFFF_FFFB);

        pulse_reset();
        issue("post_rst", 40'h0B, 40'h03, 5'h06, 40'h08);
        issue("post_rst2", 40'h0B, 40'h03, 5'h05, 40'h0E);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
